directory_engine: RTL
=====================

# directory_engine

Parametrised, sequential coherence directory for NUM_CACHES private caches over NUM_LINES tracked lines. Each entry holds a 2-bit MSI state per cache. The block accepts one request at a time and computes next states for all caches. It issues invalidate/downgrade snoops to the other holders, collects their acks, commits the entry and returns a response. It sits between the cache request arbiter and the L1 snoop ports, next to memory request logic.

## Interface
- NUM_CACHES, 4: caches tracked, ≥2.
- NUM_LINES, 64: directory entries, power of two.
- SRC_W, $clog2(NUM_CACHES): source id width.
- IDX_W, $clog2(NUM_LINES): line index width.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid / req_ready  in/out  1  request handshake.
- req_op  in  3  NOOP=0, REPLY=2, RD=3, WR=4, INV=5, UPD=6, RWITM=7.
- req_src  in  SRC_W  requesting cache.
- req_idx  in  IDX_W  line index.
- snp_valid  out  1  one-cycle snoop broadcast.
- snp_inv  out  1  1 = invalidate to I; 0 = downgrade to S.
- snp_mask  out  NUM_CACHES  targeted caches.
- snp_idx  out  IDX_W  snooped line.
- snp_ack  in  NUM_CACHES  per-cache ack pulses.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_src, rsp_idx  out  SRC_W, IDX_W  echo of the request.
- rsp_state  out  2  state granted to the source (I=0, S=1, M=2).
- rsp_err  out  1  req_src ≥ NUM_CACHES.

## Operation
- FSM: IDLE → LOOKUP → (SNOOP → WAIT)? → RESP → IDLE.
- IDLE: req_ready=1; on req_valid, latch op/src/idx and go to LOOKUP.
- LOOKUP: read the entry and compute the next vector. Per cache c≠src, with other-state s:
  - RD: source I→S, else unchanged. Others in M→S (downgrade). Others in S or I unchanged.
  - WR, UPD, RWITM: source→M. Others in S or M→I (invalidate).
  - INV: source S/M→I. Others unchanged. No snoop.
  - NOOP, REPLY, undefined codes: no change, no snoop.
  - "Source invalid" is judged from the source's own state only.
- Snoop decision: if any other cache changes state, go to SNOOP; otherwise go to RESP.
  - snp_mask = caches changing state.
  - snp_inv = 1 for WR/UPD/RWITM, 0 for RD.
- Error: if src is illegal, set rsp_err=1 and go straight to RESP with no update.
- SNOOP: assert snp_valid for 1 cycle and load pending=snp_mask, then go to WAIT.
- WAIT: each cycle, pending &= ~snp_ack.
  - Acks may arrive in any order, several per cycle.
  - Acks for non-pending bits are ignored.
  - When pending==0 (including the cycle the last ack lands), go to RESP.
- RESP entry: write the next vector into the entry (unless error) and drive the rsp_* fields.
  - rsp_state = source next state.
  - Hold all rsp_* stable until rsp_ready, then return to IDLE.
- Invariant after every commit: at most one cache in M, and M excludes S in any entry.

## Timing
- Reset (sync): all entries I, FSM IDLE, pending=0.
  - Outputs after reset: req_ready=1, snp_valid=0, snp_mask=0, rsp_valid=0, rsp_err=0, rsp_state=0.
- Reset mid-operation discards the in-flight request; the entry is not updated.
- Latency without snoop: accepted at cycle T → rsp_valid at T+2.
- Latency with snoop: snp_valid at T+2; rsp_valid one cycle after pending clears. Minimum is T+4 when all acks arrive at T+3.
- req_ready=0 in every state except IDLE. There is no back-to-back acceptance: the next request is accepted at the earliest in the cycle after the rsp handshake.
- Acks that arrive during SNOOP or before snp_valid are ignored.

## Structure
- Package dir_pkg:
  - op localparams (NOOP..RWITM);
  - state localparams I/S/M;
  - FSM state encoding;
  - function next_cache_state(op, is_src, cur).
- Sub-module dir_entry_update: combinational. Inputs: op, src, entry vector. Outputs: next vector, snoop mask, snp_inv.
- Entry storage is a flat register array of NUM_LINES × 2·NUM_CACHES bits, so a full clear on reset is possible.

## Test plan
- Reset, then RD src=1 idx=5 → rsp at T+2, rsp_state=S, no snp_valid; entry 5 = cache1 S, rest I.
- Cache0 M on idx=5, then RD src=2 → snp_valid with snp_inv=0, snp_mask=0001. Ack at T+3 → rsp_state=S at T+4; entry = {c0 S, c2 S}.
- Caches 0, 1, 3 in S, then RWITM src=2 → snp_mask=1011, snp_inv=1. Acks for c3, c0, c1 on separate cycles → rsp one cycle after the c1 ack; entry = c2 M only.
- INV src=2 on an M line → no snoop, rsp_state=I, entry all I. Holding rsp_ready=0 for 3 cycles keeps rsp_* stable and req_ready=0.
- NUM_CACHES=3, req_src=3 → rsp_err=1, entry unchanged. Spurious snp_ack during IDLE has no effect.
- rst asserted during WAIT → next cycle req_ready=1, snp_mask=0, all entries I.

Source files
------------

// File: rtl/dir_pkg.sv
// Shared encodings and the per-cache MSI transition rule for the coherence directory.
package dir_pkg;

    localparam logic [2:0] OP_NOOP  = 3'd0;
    localparam logic [2:0] OP_REPLY = 3'd2;
    localparam logic [2:0] OP_RD    = 3'd3;
    localparam logic [2:0] OP_WR    = 3'd4;
    localparam logic [2:0] OP_INV   = 3'd5;
    localparam logic [2:0] OP_UPD   = 3'd6;
    localparam logic [2:0] OP_RWITM = 3'd7;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    localparam logic [2:0] FSM_IDLE   = 3'd0;
    localparam logic [2:0] FSM_LOOKUP = 3'd1;
    localparam logic [2:0] FSM_SNOOP  = 3'd2;
    localparam logic [2:0] FSM_WAIT   = 3'd3;
    localparam logic [2:0] FSM_RESP   = 3'd4;

    function automatic logic is_excl_op(input logic [2:0] op);
        return (op == OP_WR) || (op == OP_UPD) || (op == OP_RWITM);
    endfunction

    function automatic logic [1:0] next_cache_state(input logic [2:0] op,
                                                    input logic       is_src,
                                                    input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = cur;
        case (op)
            OP_RD: begin
                if (is_src) begin
                    if (cur == ST_I) nxt = ST_S;
                end else if (cur == ST_M) begin
                    nxt = ST_S;
                end
            end
            OP_WR, OP_UPD, OP_RWITM: nxt = is_src ? ST_M : ST_I;
            OP_INV: begin
                if (is_src) nxt = ST_I;
            end
            OP_NOOP, OP_REPLY: nxt = cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dir_entry_update.sv
// Combinational next-state computation for one directory entry.
module dir_entry_update
    import dir_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int SRC_W      = $clog2(NUM_CACHES)
) (
    input  logic [2:0]              op,
    input  logic [SRC_W-1:0]        src,
    input  logic [2*NUM_CACHES-1:0] cur_vec,
    output logic [2*NUM_CACHES-1:0] next_vec,
    output logic [NUM_CACHES-1:0]   snp_mask,
    output logic                    snp_inv
);

    always_comb begin
        next_vec = '0;
        snp_mask = '0;
        for (int unsigned c = 0; c < NUM_CACHES; c++) begin
            next_vec[2*c +: 2] = next_cache_state(op, c == 32'(src), cur_vec[2*c +: 2]);
            snp_mask[c] = (c != 32'(src)) && (next_vec[2*c +: 2] != cur_vec[2*c +: 2]);
        end
    end

    assign snp_inv = is_excl_op(op);

endmodule

// File: rtl/directory_engine.sv
// MSI coherence directory: one request at a time, snoops other holders, commits and responds.
module directory_engine
    import dir_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int NUM_LINES  = 64,
    parameter int SRC_W      = $clog2(NUM_CACHES),
    parameter int IDX_W      = $clog2(NUM_LINES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [SRC_W-1:0]      req_src,
    input  logic [IDX_W-1:0]      req_idx,
    output logic                  snp_valid,
    output logic                  snp_inv,
    output logic [NUM_CACHES-1:0] snp_mask,
    output logic [IDX_W-1:0]      snp_idx,
    input  logic [NUM_CACHES-1:0] snp_ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SRC_W-1:0]      rsp_src,
    output logic [IDX_W-1:0]      rsp_idx,
    output logic [1:0]            rsp_state,
    output logic                  rsp_err
);

    localparam int VEC_W = 2 * NUM_CACHES;

    logic [2:0]            state;
    logic [2:0]            op_q;
    logic [SRC_W-1:0]      src_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic [VEC_W-1:0]      next_q;
    logic [NUM_CACHES-1:0] mask_q;
    logic                  inv_q;
    logic [NUM_CACHES-1:0] pending;
    logic [1:0]            rsp_state_q;
    logic [VEC_W-1:0]      entries [NUM_LINES];

    logic [VEC_W-1:0]      upd_next;
    logic [NUM_CACHES-1:0] upd_mask;
    logic                  upd_inv;
    logic [NUM_CACHES-1:0] pend_nxt;
    logic [1:0]            upd_src_state;
    logic [1:0]            nq_src_state;
    logic                  src_illegal;

    dir_entry_update #(
        .NUM_CACHES(NUM_CACHES),
        .SRC_W     (SRC_W)
    ) u_update (
        .op      (op_q),
        .src     (src_q),
        .cur_vec (entries[idx_q]),
        .next_vec(upd_next),
        .snp_mask(upd_mask),
        .snp_inv (upd_inv)
    );

    assign src_illegal = (32'(req_src) >= 32'(NUM_CACHES));
    assign pend_nxt    = pending & ~snp_ack;

    // Source's granted state, taken from either the fresh or the snoop-held next vector.
    always_comb begin
        upd_src_state = ST_I;
        nq_src_state  = ST_I;
        for (int unsigned c = 0; c < NUM_CACHES; c++) begin
            if (c == 32'(src_q)) begin
                upd_src_state = upd_next[2*c +: 2];
                nq_src_state  = next_q[2*c +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FSM_IDLE;
            op_q        <= OP_NOOP;
            src_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            next_q      <= '0;
            mask_q      <= '0;
            inv_q       <= 1'b0;
            pending     <= '0;
            rsp_state_q <= ST_I;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            case (state)
                FSM_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        src_q       <= req_src;
                        idx_q       <= req_idx;
                        err_q       <= src_illegal;
                        rsp_state_q <= ST_I;
                        state       <= FSM_LOOKUP;
                    end
                end
                FSM_LOOKUP: begin
                    if (err_q) begin
                        state <= FSM_RESP;
                    end else if (|upd_mask) begin
                        next_q <= upd_next;
                        mask_q <= upd_mask;
                        inv_q  <= upd_inv;
                        state  <= FSM_SNOOP;
                    end else begin
                        entries[idx_q] <= upd_next;
                        rsp_state_q    <= upd_src_state;
                        state          <= FSM_RESP;
                    end
                end
                FSM_SNOOP: begin
                    pending <= mask_q;
                    state   <= FSM_WAIT;
                end
                FSM_WAIT: begin
                    pending <= pend_nxt;
                    if (pend_nxt == '0) begin
                        entries[idx_q] <= next_q;
                        rsp_state_q    <= nq_src_state;
                        state          <= FSM_RESP;
                    end
                end
                FSM_RESP: begin
                    if (rsp_ready) state <= FSM_IDLE;
                end
                default: state <= FSM_IDLE;
            endcase
        end
    end

    assign req_ready = (state == FSM_IDLE);
    assign snp_valid = (state == FSM_SNOOP);
    assign snp_mask  = snp_valid ? mask_q : '0;
    assign snp_inv   = snp_valid & inv_q;
    assign snp_idx   = idx_q;
    assign rsp_valid = (state == FSM_RESP);
    assign rsp_src   = src_q;
    assign rsp_idx   = idx_q;
    assign rsp_state = rsp_state_q;
    assign rsp_err   = err_q;

endmodule
